// File: rtl/bus_pkg.sv
// Shared constants and types for the framed 16-bit data_in bus.
// Used by packet_framer, framer_fifo and the downstream checker.
package bus_pkg;

  localparam logic [3:0]  FRAME_HEADER = 4'hF;
  localparam logic [3:0]  BAD_HEADER   = 4'hE;
  localparam logic [15:0] IDLE_WORD    = 16'h0000;

  localparam int HDR_LSB = 12;
  localparam int SEQ_LSB = 8;
  localparam int PAY_LSB = 0;

  typedef enum logic [2:0] {
    RESET = 3'b001,
    IDLE  = 3'b010,
    SEND  = 3'b100
  } state_e;

  typedef struct packed {
    logic [3:0] hdr;
    logic [3:0] seq;
    logic [7:0] payload;
  } frame_t;

endpackage

// File: rtl/framer_fifo.sv
// Synchronous FIFO with combinational head read; DEPTH must be a power of two
// so the pointers wrap naturally.
module framer_fifo
  import bus_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/packet_framer.sv
// Buffers payload bytes and emits {hdr, seq, payload} frames on data_in.
// Optional PACKET_FRAMER_ERR_INJECT_EN adds inject_hdr / inject_seq ports.
module packet_framer
  import bus_pkg::*;
#(
  parameter int BUS_SIZE   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          payload_in,
  input  logic                payload_valid,
  output logic                payload_ready,
  output logic [BUS_SIZE-1:0] data_out,
  output logic                data_valid,
  output logic [2:0]          state
`ifdef PACKET_FRAMER_ERR_INJECT_EN
  ,
  input  logic                inject_hdr,
  input  logic                inject_seq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [3:0]          seq_q, seq_d;
  logic [BUS_SIZE-1:0] data_q, data_d;
  logic                valid_q, valid_d;

  logic       push, pop;
  logic [7:0] fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic       fifo_full, fifo_empty;
  logic       inj_hdr, inj_seq;
  frame_t     frame;

`ifdef PACKET_FRAMER_ERR_INJECT_EN
  assign inj_hdr = inject_hdr;
  assign inj_seq = inject_seq;
`else
  assign inj_hdr = 1'b0;
  assign inj_seq = 1'b0;
`endif

  // Ready is held low through the RESET state and gets no credit from a same-cycle pop.
  assign payload_ready = (state_q != RESET) && !fifo_full;
  assign push          = payload_valid && payload_ready;
  assign pop           = (state_q == SEND) && !fifo_empty;

  framer_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (payload_in),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    frame   = '0;
    data_d  = IDLE_WORD;
    valid_d = 1'b0;
    seq_d   = seq_q;
    if (pop) begin
      frame.hdr     = inj_hdr ? BAD_HEADER : FRAME_HEADER;
      frame.seq     = seq_q + {3'b000, inj_seq};
      frame.payload = fifo_dout;
      data_d        = frame;
      valid_d       = 1'b1;
      seq_d         = seq_q + 4'd1 + {3'b000, inj_seq};
    end
    // FIFO stays non-empty unless its only entry leaves with nothing arriving.
    if (state_q == RESET)                     state_d = IDLE;
    else if (push || (fifo_cnt != CW'(pop)))  state_d = SEND;
    else                                      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET;
      seq_q   <= 4'd0;
      data_q  <= IDLE_WORD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign state      = state_q;

endmodule
